// File: rtl/fp_add_arb_pkg.sv
// Shared definitions for the FP adder arbiter: float format defaults,
// FSM state encoding and a few handy float constants.
// Imported by fp_add_arbiter and its sub-modules.
package fp_add_arb_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_EXP      = 8;
  localparam int FP_MANTISSA = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  localparam logic [31:0] FP_ONE = 32'h3F800000;
  localparam logic [31:0] FP_TWO = 32'h40000000;
  localparam logic [31:0] FP_MAX = 32'h7F7FFFFF;

endpackage

// File: rtl/IEEE_SP_FP_Addr.sv
// Combinational floating-point adder (sign/exponent/mantissa, no rounding: truncates).
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b operands; sum_out result; overflow_flag (result exponent saturates,
//   sum is signed infinity); underflow_flag (nonzero result below the smallest
//   normal, sum is flushed to signed zero). Subnormal inputs are treated as zero.
module IEEE_SP_FP_Addr #(
  parameter int EXP      = 8,
  parameter int MANTISSA = 23
) (
  input  logic [EXP+MANTISSA:0] a,
  input  logic [EXP+MANTISSA:0] b,
  output logic [EXP+MANTISSA:0] sum_out,
  output logic                  overflow_flag,
  output logic                  underflow_flag
);

  localparam int W    = EXP + MANTISSA + 1;
  // carry + hidden bit + mantissa + 3 guard bits
  localparam int SW   = MANTISSA + 5;
  localparam int EMAX = (1 << EXP) - 1;

  logic           a_big;
  logic           s_big;
  logic           s_small;
  logic [EXP-1:0] e_big;
  logic [EXP-1:0] e_small;
  logic [EXP-1:0] shamt;
  logic [SW-1:0]  m_big;
  logic [SW-1:0]  m_small;
  logic [SW-1:0]  sum_ext;
  int             e_res;

  always_comb begin
    // Order operands by magnitude so the subtraction never goes negative.
    a_big   = (a[W-2:0] >= b[W-2:0]);
    s_big   = a_big ? a[W-1] : b[W-1];
    s_small = a_big ? b[W-1] : a[W-1];
    e_big   = a_big ? a[W-2 -: EXP] : b[W-2 -: EXP];
    e_small = a_big ? b[W-2 -: EXP] : a[W-2 -: EXP];
    m_big   = {1'b0, (e_big != '0),
               (e_big != '0) ? (a_big ? a[MANTISSA-1:0] : b[MANTISSA-1:0]) : {MANTISSA{1'b0}},
               3'b000};
    m_small = {1'b0, (e_small != '0),
               (e_small != '0) ? (a_big ? b[MANTISSA-1:0] : a[MANTISSA-1:0]) : {MANTISSA{1'b0}},
               3'b000};
    shamt   = e_big - e_small;
    if (int'(shamt) >= SW) begin
      m_small = '0;
    end else begin
      m_small = m_small >> shamt;
    end

    if (s_big == s_small) begin
      sum_ext = m_big + m_small;
    end else begin
      sum_ext = m_big - m_small;
    end

    e_res = int'(e_big);
    if (sum_ext[SW-1]) begin
      sum_ext = sum_ext >> 1;
      e_res   = e_res + 1;
    end else begin
      // Left-normalise until the hidden bit position holds a one.
      for (int i = 0; i < SW - 2; i++) begin
        if ((sum_ext != '0) && !sum_ext[SW-2]) begin
          sum_ext = sum_ext << 1;
          e_res   = e_res - 1;
        end
      end
    end

    overflow_flag  = 1'b0;
    underflow_flag = 1'b0;
    sum_out        = {s_big, e_res[EXP-1:0], sum_ext[SW-3 -: MANTISSA]};
    if (sum_ext == '0) begin
      sum_out = '0;
    end else if (e_res >= EMAX) begin
      overflow_flag = 1'b1;
      sum_out       = {s_big, {EXP{1'b1}}, {MANTISSA{1'b0}}};
    end else if (e_res <= 0) begin
      underflow_flag = 1'b1;
      sum_out        = {s_big, {(W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, wrapping modulo NUM_REQ.
// Latency: 0 cycles (combinational). Backpressure: en=0 forces no grant.
// Ports: req (request vector), ptr (search start), en; gnt (one-hot), gnt_idx.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && en && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one IEEE_SP_FP_Addr between NUM_REQ requesters with round-robin grants.
// Latency: accept edge -> rsp_valid on the next edge; 1 result per 2 cycles at best.
// Backpressure: while rsp_valid & !rsp_ready, rsp_* hold and req_ready stays 0.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b per requester
//   (slice i = [i*WIDTH +: WIDTH]); rsp_valid/rsp_ready/rsp_sum/rsp_id/rsp_overflow/
//   rsp_underflow. Optional FP_ARB_STICKY_FLAGS_EN adds sticky_clr, sticky_ovf, sticky_unf.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int WIDTH    = FP_WIDTH,
  parameter  int EXP      = FP_EXP,
  parameter  int MANTISSA = FP_MANTISSA,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef FP_ARB_STICKY_FLAGS_EN
  input  logic                     sticky_clr,
  output logic [NUM_REQ-1:0]       sticky_ovf,
  output logic [NUM_REQ-1:0]       sticky_unf,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_overflow,
  output logic                     rsp_underflow
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]    op_id_q, op_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_unf_q, rsp_unf_d;

  logic               rsp_hs;
  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_ovf;
  logic               add_unf;

  assign rsp_hs = rsp_valid_q & rsp_ready;
  // Grants are possible when idle, or when the held result leaves this cycle.
  // Gating with rst_n keeps req_ready low throughout reset.
  assign arb_en = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & rsp_hs));
  assign accept = |gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  IEEE_SP_FP_Addr #(.EXP(EXP), .MANTISSA(MANTISSA)) u_add (
    .a              (op_a_q),
    .b              (op_b_q),
    .sum_out        (add_sum),
    .overflow_flag  (add_ovf),
    .underflow_flag (add_unf)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_unf_d   = rsp_unf_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        rsp_sum_d   = add_sum;
        rsp_id_d    = op_id_q;
        rsp_ovf_d   = add_ovf;
        rsp_unf_d   = add_unf;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // accept can only fire in IDLE or on the HOLD handshake; both go to ISSUE.
    if (accept) begin
      op_a_d   = sel_a;
      op_b_d   = sel_b;
      op_id_d  = gnt_idx;
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_unf_q   <= rsp_unf_d;
    end
  end

  assign req_ready     = gnt;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_sum       = rsp_sum_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;

`ifdef FP_ARB_STICKY_FLAGS_EN
  logic [NUM_REQ-1:0] sticky_ovf_q, sticky_ovf_d;
  logic [NUM_REQ-1:0] sticky_unf_q, sticky_unf_d;
  logic [NUM_REQ-1:0] set_ovf;
  logic [NUM_REQ-1:0] set_unf;

  // Clear is applied first so a coincident set survives.
  always_comb begin
    set_ovf = '0;
    set_unf = '0;
    if (rsp_hs && rsp_ovf_q) set_ovf[rsp_id_q] = 1'b1;
    if (rsp_hs && rsp_unf_q) set_unf[rsp_id_q] = 1'b1;
    sticky_ovf_d = (sticky_clr ? '0 : sticky_ovf_q) | set_ovf;
    sticky_unf_d = (sticky_clr ? '0 : sticky_unf_q) | set_unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q <= '0;
      sticky_unf_q <= '0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: per-requester drivers, a negedge monitor
// holding a round-robin reference and an expected-response queue.
module tb_fp_add_arbiter;
  import fp_add_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic [1:0]     rsp_id;
  logic           rsp_overflow;
  logic           rsp_underflow;
`ifdef FP_ARB_STICKY_FLAGS_EN
  logic           sticky_clr = 1'b0;
  logic [N-1:0]   sticky_ovf;
  logic [N-1:0]   sticky_unf;
`endif

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef FP_ARB_STICKY_FLAGS_EN
    .sticky_clr    (sticky_clr),
    .sticky_ovf    (sticky_ovf),
    .sticky_unf    (sticky_unf),
`endif
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_sum       (rsp_sum),
    .rsp_id        (rsp_id),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow)
  );

  typedef struct {
    logic [31:0] sum;
    int          id;
    bit          ovf;
    bit          unf;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          grant_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          m_ptr  = 0;
  bit [N-1:0]  want     = '0;
  bit [N-1:0]  accepted = '0;
  logic [31:0] a_bits[N];
  logic [31:0] b_bits[N];
  logic [31:0] s_bits[N];
  bit          o_bits[N];
  bit          u_bits[N];

  // Exact float encoding of a small integer (|n| < 2^24).
  function automatic logic [31:0] fp(input int n);
    logic [31:0] mag;
    int          p;
    mag = (n < 0) ? 32'(-n) : 32'(n);
    if (mag == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 32; k++) if (mag[k]) p = k;
    return {(n < 0), 8'(127 + p), 23'(mag << (23 - p))};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_bits[i];
      req_b[i*W +: W] = b_bits[i];
    end
    req_valid = want;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    want     = want & ~accepted;
    accepted = '0;
    drive();
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] s, input bit o, input bit u);
    if (!want[i]) begin
      a_bits[i] = a; b_bits[i] = b; s_bits[i] = s;
      o_bits[i] = o; u_bits[i] = u;
      want[i]   = 1'b1;
      drive();
    end
  endtask

  task automatic post_int(input int i, input int x, input int y);
    post(i, fp(x), fp(y), fp(x + y), 1'b0, 1'b0);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (sbq.size() == 0 && want == '0) break;
      step();
    end
    check("drain_complete", 64'(sbq.size() == 0 && want == '0), 64'(1));
  endtask

  // Monitor: at most one transaction in flight; its response is due two
  // negedges after the grant and a new grant is allowed once nothing is
  // outstanding (or the outstanding response leaves this cycle).
  task automatic monitor_cycle();
    bit         exp_v;
    int         w;
    bit [N-1:0] eg;
    exp_t       e;
    cyc++;
    exp_v = (sbq.size() > 0) && (sbq[0].cyc <= cyc - 2);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    if (rsp_valid && exp_v) begin
      check("rsp_sum", 64'(rsp_sum), 64'(sbq[0].sum));
      check("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
      check("rsp_flags", 64'({rsp_overflow, rsp_underflow}), 64'({sbq[0].ovf, sbq[0].unf}));
      if (rsp_ready) void'(sbq.pop_front());
    end
    w  = -1;
    eg = '0;
    if (sbq.size() == 0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(eg));
    for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
    if (w >= 0) begin
      e.sum = s_bits[w]; e.id = w; e.ovf = o_bits[w]; e.unf = u_bits[w]; e.cyc = cyc;
      sbq.push_back(e);
      m_ptr       = (w + 1) % N;
      accepted[w] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) monitor_cycle();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_log(input string name, input int pos, input int exp);
    if (grant_log.size() > pos) check(name, 64'(grant_log[pos]), 64'(exp));
    else check(name, 64'(-1), 64'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_bits[i] = '0; b_bits[i] = '0; s_bits[i] = '0; o_bits[i] = 0; u_bits[i] = 0;
    end
    for (int i = 0; i < N; i++) post_int(i, i + 1, 10 * i);
    #12;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_flags", 64'({rsp_overflow, rsp_underflow}), 64'(0));

    // All four requesters held valid: round-robin 0,1,2,3,0.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    for (int c = 0; c < 10; c++) begin
      step();
      for (int i = 0; i < N; i++) post_int(i, i + 1, 10 * i + c);
    end
    check_log("rr_order_0", 0, 0);
    check_log("rr_order_1", 1, 1);
    check_log("rr_order_2", 2, 2);
    check_log("rr_order_3", 3, 3);
    check_log("rr_order_4", 4, 0);
    drain();

    // 1.0 + 2.0 on requester 0.
    grant_log.delete();
    post(0, FP_ONE, FP_TWO, 32'h40400000, 1'b0, 1'b0);
    drain();
    check("single_grant_count", 64'(grant_log.size()), 64'(1));
    check_log("single_grant_id", 0, 0);

    // Serve 2, stall the consumer with 0,1,3 pending, then release.
    grant_log.delete();
    rsp_ready = 1'b0;
    post_int(2, 100, -37);
    repeat (3) step();
    post_int(0, 5, 5);
    post_int(1, -8, 3);
    post_int(3, 700, 300);
    repeat (5) step();
    rsp_ready = 1'b1;
    drain();
    check_log("bp_order_0", 0, 2);
    check_log("bp_order_1", 1, 3);
    check_log("bp_order_2", 2, 0);
    check_log("bp_order_3", 3, 1);

    // Overflow on requester 1, flushed underflow on requester 2.
    post(1, FP_MAX, FP_MAX, 32'h7F800000, 1'b1, 1'b0);
    post(2, 32'h00C00000, 32'h80800000, 32'h00000000, 1'b0, 1'b1);
    drain();

    // Asynchronous reset while a transaction is in ISSUE.
    post_int(1, 5, 6);
    step();
    post_int(2, 9, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("arst_req_ready", 64'(req_ready), 64'(0));
    check("arst_rsp_id", 64'(rsp_id), 64'(0));
    sbq.delete();
    accepted = '0;
    m_ptr    = 0;
    post_int(0, 7, 8);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    drain();
    check_log("arst_first_grant", 0, 0);
    check_log("arst_second_grant", 1, 2);

    // Only req 3, then only req 0: pointer wraps 3 -> 0.
    grant_log.delete();
    post_int(3, 1, 1);
    step();
    step();
    post_int(0, 2, 2);
    drain();
    check_log("wrap_0", 0, 3);
    check_log("wrap_1", 1, 0);

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 1500; c++) begin
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        if (!want[i] && ($urandom % 3) == 0) begin
          if (($urandom % 16) == 0) post(i, FP_MAX, FP_MAX, 32'h7F800000, 1'b1, 1'b0);
          else post_int(i, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
        end
      end
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
